// File: rtl/io_pkg.sv
// Shared definitions for the switch input peripheral.
// Word selects, button FSM states and the default debounce length.
package io_pkg;

    localparam logic [1:0] SEL_SW_LO  = 2'd0;
    localparam logic [1:0] SEL_SW_HI  = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_ZERO   = 2'd3;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t B_IDLE    = 2'd0;
    localparam btn_state_t B_PRESS   = 2'd1;
    localparam btn_state_t B_HELD    = 2'd2;
    localparam btn_state_t B_RELEASE = 2'd3;

    localparam int DEFAULT_DB_CYCLES = 100000;

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by an optional shared-counter debounce.
// With FILTER = 0 the stable output is simply the synchronised input.
module debounce_cell
    import io_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int DB_W      = 17,
    parameter bit FILTER    = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    // Bring the asynchronous pins into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    generate
        if (FILTER) begin : g_filter
            localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

            logic [WIDTH-1:0] prev;
            logic [WIDTH-1:0] stable_q;
            logic [DB_W-1:0]  count;

            // Accept a new level only after it has been steady long enough.
            always_ff @(posedge clock) begin
                if (reset) begin
                    prev     <= '0;
                    stable_q <= '0;
                    count    <= '0;
                end else begin
                    prev <= sync;
                    if (sync == stable_q) begin
                        count <= '0;
                    end else if (sync != prev) begin
                        count <= '0;
                    end else if (count == DB_LAST) begin
                        stable_q <= sync;
                        count    <= '0;
                    end else begin
                        count <= count + DB_W'(1);
                    end
                end
            end

            assign stable = stable_q;
        end else begin : g_pass
            assign stable = sync;
        end
    endgenerate

endmodule

// File: rtl/switch_input.sv
// Memory-mapped switch/button input port with sticky press event.
// Define SWITCH_DEBOUNCE_EN to enable counter-based debouncing.
module switch_input
    import io_pkg::*;
#(
    parameter int SW_WIDTH  = 24,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int DB_W      = 17
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                SwitchCtrl,
    input  logic                ioRead,
    input  logic [1:0]          reg_sel,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                button,
    output logic [15:0]         read_data,
    output logic                btn_event
);

`ifdef SWITCH_DEBOUNCE_EN
    localparam bit FILTER = 1'b1;
    localparam int EFF_DB = DB_CYCLES;
`else
    localparam bit FILTER = 1'b0;
    localparam int EFF_DB = 1;
`endif

    // Counter value on the last of EFF_DB consecutive samples
    // (the first sample is the one that leaves IDLE/HELD).
    localparam logic [DB_W-1:0] DB_LAST =
        (EFF_DB > 1) ? DB_W'(EFF_DB - 2) : '0;

    logic [SW_WIDTH-1:0] sw_stable;
    logic                btn_sync;
    btn_state_t          state;
    logic [DB_W-1:0]     cnt;
    logic                press_set;
    logic                rd;
    logic [31:0]         sw_ext;
    logic [15:0]         rd_word;

    debounce_cell #(
        .WIDTH     (SW_WIDTH),
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W),
        .FILTER    (FILTER)
    ) u_sw_db (
        .clock  (clock),
        .reset  (reset),
        .raw    (switches),
        .stable (sw_stable)
    );

    // The button FSM does its own filtering, so only sync here.
    debounce_cell #(
        .WIDTH     (1),
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W),
        .FILTER    (1'b0)
    ) u_btn_sync (
        .clock  (clock),
        .reset  (reset),
        .raw    (button),
        .stable (btn_sync)
    );

    // A press is accepted on the sample that completes the run of 1s.
    always_comb begin
        press_set = 1'b0;
        if (btn_sync) begin
            if (state == B_IDLE && EFF_DB == 1) begin
                press_set = 1'b1;
            end else if (state == B_PRESS && cnt == DB_LAST) begin
                press_set = 1'b1;
            end
        end
    end

    // Button press/release state machine.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= B_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                B_IDLE: begin
                    cnt <= '0;
                    if (btn_sync) begin
                        state <= press_set ? B_HELD : B_PRESS;
                    end
                end
                B_PRESS: begin
                    if (!btn_sync) begin
                        state <= B_IDLE;
                        cnt   <= '0;
                    end else if (press_set) begin
                        state <= B_HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                B_HELD: begin
                    cnt <= '0;
                    if (!btn_sync) begin
                        state <= (EFF_DB == 1) ? B_IDLE : B_RELEASE;
                    end
                end
                B_RELEASE: begin
                    if (btn_sync) begin
                        state <= B_HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= B_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= B_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rd     = SwitchCtrl && ioRead;
    assign sw_ext = 32'(sw_stable);

    // Read word multiplexer.
    always_comb begin
        rd_word = 16'h0000;
        case (reg_sel)
            SEL_SW_LO:  rd_word = sw_ext[15:0];
            SEL_SW_HI:  rd_word = sw_ext[31:16];
            SEL_STATUS: rd_word = {15'b0, btn_event};
            default:    rd_word = 16'h0000;
        endcase
    end

    // Registered read data and sticky event; a new press beats a clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data <= 16'h0000;
            btn_event <= 1'b0;
        end else begin
            if (rd) begin
                read_data <= rd_word;
            end
            if (press_set) begin
                btn_event <= 1'b1;
            end else if (rd && reg_sel == SEL_STATUS) begin
                btn_event <= 1'b0;
            end
        end
    end

endmodule
